// File: rtl/unified_mem_arbiter.sv
// Shares one single-ported, variable-latency memory between the fetch and load/store ports.
// Define ARB_ROUND_ROBIN_EN to alternate simultaneous requests instead of fixed dm priority.
module unified_mem_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    if_req,
  input  logic [ADDR_WIDTH-1:0]   if_addr,
  output logic                    if_gnt,
  output logic                    if_rvalid,
  output logic [DATA_WIDTH-1:0]   if_rdata,
  input  logic                    dm_req,
  input  logic                    dm_we,
  input  logic [DATA_WIDTH/8-1:0] dm_be,
  input  logic [ADDR_WIDTH-1:0]   dm_addr,
  input  logic [DATA_WIDTH-1:0]   dm_wdata,
  output logic                    dm_gnt,
  output logic                    dm_rvalid,
  output logic [DATA_WIDTH-1:0]   dm_rdata,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [DATA_WIDTH/8-1:0] mem_be,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  input  logic                    mem_gnt,
  input  logic                    mem_rvalid,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  output logic                    err,
  output logic                    busy
);

  localparam int BE_WIDTH  = DATA_WIDTH / 8;
  localparam int CNT_WIDTH = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam logic OWNER_FETCH = 1'b0;
  localparam logic OWNER_DM    = 1'b1;

  logic [1:0]            r_state;
  logic [CNT_WIDTH-1:0]  r_cnt;
  logic                  r_owner;
  logic                  r_if_gnt;
  logic                  r_dm_gnt;
  logic                  r_if_rvalid;
  logic                  r_dm_rvalid;
  logic [DATA_WIDTH-1:0] r_if_rdata;
  logic [DATA_WIDTH-1:0] r_dm_rdata;
  logic                  r_mem_req;
  logic                  r_mem_we;
  logic [BE_WIDTH-1:0]   r_mem_be;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0] r_mem_wdata;
  logic                  r_err;
  logic                  r_busy;

  logic                  w_any_req;
  logic                  w_pick_dm;
  logic                  w_timeout;
  logic                  w_done;
  logic [DATA_WIDTH-1:0] w_resp_data;

  assign w_any_req = if_req | dm_req;

`ifdef ARB_ROUND_ROBIN_EN
  logic r_last;

  // On a tie the port that was not served last wins.
  assign w_pick_dm = dm_req & (~if_req | (r_last == OWNER_FETCH));
`else
  assign w_pick_dm = dm_req;
`endif

  // A response arriving alongside the grant in ISSUE skips WAIT entirely.
  assign w_timeout   = (r_state == S_WAIT) && !mem_rvalid && (r_cnt == CNT_MAX);
  assign w_done      = ((r_state == S_ISSUE) && mem_gnt && mem_rvalid) ||
                       ((r_state == S_WAIT) && (mem_rvalid || w_timeout));
  assign w_resp_data = (w_timeout || r_mem_we) ? '0 : mem_rdata;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_owner     <= OWNER_FETCH;
      r_if_gnt    <= 1'b0;
      r_dm_gnt    <= 1'b0;
      r_if_rvalid <= 1'b0;
      r_dm_rvalid <= 1'b0;
      r_if_rdata  <= '0;
      r_dm_rdata  <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_be    <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_err       <= 1'b0;
      r_busy      <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      r_last      <= OWNER_FETCH;
`endif
    end else begin
      r_if_gnt    <= 1'b0;
      r_dm_gnt    <= 1'b0;
      r_if_rvalid <= 1'b0;
      r_dm_rvalid <= 1'b0;
      r_err       <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_state   <= S_ISSUE;
            r_busy    <= 1'b1;
            r_mem_req <= 1'b1;
            r_owner   <= w_pick_dm ? OWNER_DM : OWNER_FETCH;
`ifdef ARB_ROUND_ROBIN_EN
            r_last    <= w_pick_dm ? OWNER_DM : OWNER_FETCH;
`endif
            if (w_pick_dm) begin
              r_dm_gnt    <= 1'b1;
              r_mem_we    <= dm_we;
              r_mem_be    <= dm_be;
              r_mem_addr  <= dm_addr;
              r_mem_wdata <= dm_wdata;
            end else begin
              r_if_gnt    <= 1'b1;
              r_mem_we    <= 1'b0;
              r_mem_be    <= '1;
              r_mem_addr  <= if_addr;
              r_mem_wdata <= '0;
            end
          end
        end
        S_ISSUE: begin
          if (mem_gnt) begin
            r_mem_req <= 1'b0;
            r_cnt     <= '0;
            r_state   <= mem_rvalid ? S_RESP : S_WAIT;
          end
        end
        S_WAIT: begin
          if (w_done) begin
            r_state <= S_RESP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase

      // Response data is registered here so it appears during RESP.
      if (w_done) begin
        if (r_owner == OWNER_DM) begin
          r_dm_rvalid <= 1'b1;
          r_dm_rdata  <= w_resp_data;
        end else begin
          r_if_rvalid <= 1'b1;
          r_if_rdata  <= w_resp_data;
        end
        r_err <= w_timeout;
      end
    end
  end

  assign if_gnt    = r_if_gnt;
  assign if_rvalid = r_if_rvalid;
  assign if_rdata  = r_if_rdata;
  assign dm_gnt    = r_dm_gnt;
  assign dm_rvalid = r_dm_rvalid;
  assign dm_rdata  = r_dm_rdata;
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_be    = r_mem_be;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign err       = r_err;
  assign busy      = r_busy;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Scoreboard bench for unified_mem_arbiter with a configurable memory responder.
// Builds with or without ARB_ROUND_ROBIN_EN; the extra round-robin sequence runs only when defined.
module tb_unified_mem_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_gnt, if_rvalid;
  logic [31:0] if_rdata;
  logic        dm_req = 1'b0;
  logic        dm_we = 1'b0;
  logic [3:0]  dm_be = '0;
  logic [31:0] dm_addr = '0;
  logic [31:0] dm_wdata = '0;
  logic        dm_gnt, dm_rvalid;
  logic [31:0] dm_rdata;
  logic        mem_req, mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;
  logic        err, busy;

  unified_mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(8)) dut (
    .clock(clock), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .err(err), .busy(busy)
  );

  always #5 clock = ~clock;

  int cycleNo = 0;
  always @(posedge clock) cycleNo <= cycleNo + 1;

  int checkCount = 0;
  int errorCount = 0;
  int rvalidCount = 0;

  typedef struct {
    bit          isDm;
    logic [31:0] data;
    bit          err;
    int          cycle;
  } sbEntry_t;

  sbEntry_t sbQ[$];

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, actual, expected, cycleNo);
    end
  endtask

  // Memory responder: grants after cfgGntWait cycles, answers cfgLat cycles after the grant.
  int          cfgGntWait = 0;
  int          cfgLat = 1;
  bit          cfgSame = 0;
  logic [31:0] respData = '0;

  initial begin
    bit          memActive;
    int          gntCnt;
    int          rvCnt;
    logic [31:0] pendData;
    memActive = 0; gntCnt = -1; rvCnt = 0; pendData = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    forever begin
      @(posedge clock); #1;
      mem_gnt = 1'b0;
      mem_rvalid = 1'b0;
      if (rvCnt == 1) begin
        mem_rvalid = 1'b1;
        mem_rdata  = pendData;
      end
      if (rvCnt > 0) rvCnt--;
      if (!mem_req) memActive = 0;
      else if (!memActive) begin
        memActive = 1;
        gntCnt = cfgGntWait;
      end
      if (memActive && gntCnt >= 0) begin
        if (gntCnt == 0) begin
          mem_gnt = 1'b1;
          gntCnt = -1;
          pendData = respData;
          if (cfgSame) begin
            mem_rvalid = 1'b1;
            mem_rdata  = respData;
          end else begin
            rvCnt = cfgLat;
          end
        end else begin
          gntCnt--;
        end
      end
    end
  end

  // Every response pulse is matched against the oldest expected entry.
  always @(negedge clock) begin
    sbEntry_t e;
    if (if_rvalid || dm_rvalid) begin
      rvalidCount++;
      if (sbQ.size() == 0) begin
        checkOutput("unexpectedRvalid", {if_rvalid, dm_rvalid}, 2'b00);
      end else begin
        e = sbQ.pop_front();
        checkOutput("rvalidPort", {if_rvalid, dm_rvalid}, e.isDm ? 2'b01 : 2'b10);
        checkOutput("rdata", e.isDm ? dm_rdata : if_rdata, e.data);
        checkOutput("errFlag", err, e.err);
        checkOutput("rvalidCycle", cycleNo, e.cycle);
      end
    end else if (err) begin
      checkOutput("strayErr", err, 1'b0);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic doReset();
    @(posedge clock); #1;
    reset = 1'b1; if_req = 1'b0; dm_req = 1'b0;
    @(posedge clock); #1;
    @(negedge clock);
    checkOutput("rstCtrl", {busy, mem_req, if_gnt, dm_gnt, if_rvalid, dm_rvalid, err, mem_we}, 8'h00);
    checkOutput("rstIfRdata", if_rdata, 32'h0);
    checkOutput("rstDmRdata", dm_rdata, 32'h0);
    checkOutput("rstMemFields", {mem_be, mem_addr, mem_wdata}, 68'h0);
    @(posedge clock); #1;
    reset = 1'b0;
    sbQ.delete();
  endtask

  task automatic applyStimulus(input bit isDm, input bit we, input logic [3:0] be,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [31:0] expData, input bit expErr,
                               input int rvOffset, output int startCycle);
    bit seen;
    @(posedge clock); #1;
    startCycle = cycleNo;
    if (isDm) begin
      dm_req = 1'b1; dm_we = we; dm_be = be; dm_addr = addr; dm_wdata = wdata;
    end else begin
      if_req = 1'b1; if_addr = addr;
    end
    sbQ.push_back('{isDm, expData, expErr, startCycle + rvOffset});
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clock);
      if (isDm ? dm_gnt : if_gnt) seen = 1;
    end
    checkOutput("gntSeen", seen, 1'b1);
    checkOutput("gntCycle", cycleNo, startCycle + 1);
    checkOutput("issueReq", {mem_req, busy}, 2'b11);
    checkOutput("issueAddr", mem_addr, addr);
    checkOutput("issueBe", mem_be, isDm ? be : 4'hF);
    checkOutput("issueWe", mem_we, isDm ? we : 1'b0);
    checkOutput("issueWdata", mem_wdata, isDm ? wdata : 32'h0);
    @(posedge clock); #1;
    if (isDm) dm_req = 1'b0; else if_req = 1'b0;
  endtask

  task automatic waitIdle(output int idleCycle);
    for (int i = 0; i < 40 && busy; i++) @(negedge clock);
    if (busy) @(negedge clock);
    idleCycle = cycleNo;
    checkOutput("waitIdle", busy, 1'b0);
    checkOutput("sbDrained", sbQ.size(), 0);
  endtask

  initial begin
    int n, idleAt, rvBefore;
    bit seen;
    bit expDm[3];

    doReset();

    // Single fetch against a zero-wait memory.
    cfgGntWait = 0; cfgLat = 1; respData = 32'h0050_0093;
    applyStimulus(1'b0, 1'b0, 4'hF, 32'h100, 32'h0, 32'h0050_0093, 1'b0, 3, n);
    waitIdle(idleAt);
    checkOutput("fetchIdleCycle", idleAt, n + 4);

    // Store with a memory that withholds its grant for three cycles.
    cfgGntWait = 3; respData = 32'h1234_5678;
    applyStimulus(1'b1, 1'b1, 4'h3, 32'h200, 32'hBEEF, 32'h0, 1'b0, 6, n);
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      checkOutput("stallReq", mem_req, 1'b1);
      checkOutput("stallFields", {mem_we, mem_be, mem_addr, mem_wdata}, {1'b1, 4'h3, 32'h200, 32'hBEEF});
    end
    @(negedge clock);
    checkOutput("stallReqDrop", mem_req, 1'b0);
    waitIdle(idleAt);
    checkOutput("ifRdataHold", if_rdata, 32'h0050_0093);

    // Simultaneous requests right after reset: dm first, then the held fetch.
    cfgGntWait = 0;
    doReset();
    respData = 32'h1111_2222;
    @(posedge clock); #1;
    n = cycleNo;
    if_req = 1'b1; if_addr = 32'h300;
    dm_req = 1'b1; dm_we = 1'b0; dm_be = 4'hF; dm_addr = 32'h400; dm_wdata = 32'h0;
    sbQ.push_back('{1'b1, 32'h1111_2222, 1'b0, n + 3});
    sbQ.push_back('{1'b0, 32'h1111_2222, 1'b0, n + 7});
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clock);
      if (if_gnt || dm_gnt) seen = 1;
    end
    checkOutput("arbFirstGnt", {if_gnt, dm_gnt}, 2'b01);
    checkOutput("arbFirstCycle", cycleNo, n + 1);
    @(posedge clock); #1;
    dm_req = 1'b0;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clock);
      if (if_gnt || dm_gnt) seen = 1;
    end
    checkOutput("arbSecondGnt", {if_gnt, dm_gnt}, 2'b10);
    checkOutput("arbSecondCycle", cycleNo, n + 5);
    @(posedge clock); #1;
    if_req = 1'b0;
    waitIdle(idleAt);

`ifdef ARB_ROUND_ROBIN_EN
    // Both ports request continuously: grants alternate starting with dm.
    doReset();
    expDm[0] = 1'b1; expDm[1] = 1'b0; expDm[2] = 1'b1;
    @(posedge clock); #1;
    n = cycleNo;
    if_req = 1'b1; if_addr = 32'h500;
    dm_req = 1'b1; dm_we = 1'b0; dm_be = 4'hF; dm_addr = 32'h600;
    for (int i = 0; i < 3; i++) sbQ.push_back('{expDm[i], 32'h1111_2222, 1'b0, n + 3 + 4 * i});
    for (int g = 0; g < 3; g++) begin
      seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
        @(negedge clock);
        if (if_gnt || dm_gnt) seen = 1;
      end
      checkOutput("rrGntDm", {if_gnt, dm_gnt}, expDm[g] ? 2'b01 : 2'b10);
      checkOutput("rrGntCycle", cycleNo, n + 1 + 4 * g);
    end
    @(posedge clock); #1;
    if_req = 1'b0; dm_req = 1'b0;
    waitIdle(idleAt);
`else
    expDm[0] = 1'b0; expDm[1] = 1'b0; expDm[2] = 1'b0;
`endif

    // Timeout: the memory answers only after the arbiter has given up.
    cfgLat = 11; respData = 32'hDEAD_BEEF;
    applyStimulus(1'b1, 1'b0, 4'hF, 32'h700, 32'h0, 32'h0, 1'b1, 10, n);
    waitIdle(idleAt);
    rvBefore = rvalidCount;
    repeat (4) @(negedge clock);
    checkOutput("lateRvalidIgnored", rvalidCount, rvBefore);
    checkOutput("lateBusy", busy, 1'b0);
    checkOutput("timeoutRdataZero", dm_rdata, 32'h0);

    // Grant and response in the same ISSUE cycle.
    cfgLat = 1; cfgSame = 1; respData = 32'hCAFE_F00D;
    applyStimulus(1'b1, 1'b0, 4'hF, 32'h800, 32'h0, 32'hCAFE_F00D, 1'b0, 2, n);
    waitIdle(idleAt);
    checkOutput("sameCycleIdle", idleAt, n + 3);
    cfgSame = 0;

    // Reset while a load sits in WAIT abandons it.
    cfgLat = 5; respData = 32'h5555_AAAA;
    @(posedge clock); #1;
    n = cycleNo;
    dm_req = 1'b1; dm_we = 1'b0; dm_be = 4'hF; dm_addr = 32'hA00; dm_wdata = 32'h0;
    @(negedge clock);
    @(negedge clock);
    checkOutput("rstWaitGnt", dm_gnt, 1'b1);
    @(posedge clock); #1;
    dm_req = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    rvBefore = rvalidCount;
    @(negedge clock);
    checkOutput("rstWaitCtrl", {busy, mem_req, if_gnt, dm_gnt, if_rvalid, dm_rvalid, err}, 7'h00);
    checkOutput("rstWaitRdata", {if_rdata, dm_rdata}, 64'h0);
    checkOutput("rstWaitCycle", cycleNo, n + 4);
    repeat (4) @(negedge clock);
    checkOutput("rstLateIgnored", rvalidCount, rvBefore);
    checkOutput("rstStillIdle", busy, 1'b0);

    cfgLat = 1; respData = 32'h0BAD_F00D;
    applyStimulus(1'b0, 1'b0, 4'hF, 32'h900, 32'h0, 32'h0BAD_F00D, 1'b0, 3, n);
    waitIdle(idleAt);
    checkOutput("postRstIdle", idleAt, n + 4);

    repeat (2) @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
